// File: rtl/cache_port_arbiter.sv
// Two-port front end for a single cache: picks one requester (round-robin or
// fixed priority), holds it through a miss refill, returns read data and counts activity.
module cache_port_arbiter #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_LEN    = 32
) (
    input  logic                clk,
    input  logic                rst,
    // port 0: instruction fetch
    input  logic                p0_rd_req,
    input  logic                p0_wr_req,
    input  logic [ADDR_LEN-1:0] p0_addr,
    input  logic [DATA_LEN-1:0] p0_wr_data,
    output logic                p0_stall,
    output logic                p0_rd_valid,
    output logic [DATA_LEN-1:0] p0_rd_data,
    // port 1: data memory stage
    input  logic                p1_rd_req,
    input  logic                p1_wr_req,
    input  logic [ADDR_LEN-1:0] p1_addr,
    input  logic [DATA_LEN-1:0] p1_wr_data,
    output logic                p1_stall,
    output logic                p1_rd_valid,
    output logic [DATA_LEN-1:0] p1_rd_data,
    // cache side
    input  logic                c_miss,
    output logic [ADDR_LEN-1:0] c_addr,
    output logic                c_rd_req,
    output logic                c_wr_req,
    output logic [DATA_LEN-1:0] c_wr_data,
    input  logic [DATA_LEN-1:0] c_rd_data,
    // performance counters
    output logic [CNT_LEN-1:0]  cnt_done0,
    output logic [CNT_LEN-1:0]  cnt_done1,
    output logic [CNT_LEN-1:0]  cnt_wait0,
    output logic [CNT_LEN-1:0]  cnt_wait1
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   lock_port_q, lock_port_d;
    logic   rr_ptr_q, rr_ptr_d;

    logic [1:0]          rd_valid_q, rd_valid_d;
    logic [DATA_LEN-1:0] rd_data_q  [2];
    logic [DATA_LEN-1:0] rd_data_d  [2];
    logic [CNT_LEN-1:0]  cnt_done_q [2];
    logic [CNT_LEN-1:0]  cnt_done_d [2];
    logic [CNT_LEN-1:0]  cnt_wait_q [2];
    logic [CNT_LEN-1:0]  cnt_wait_d [2];

    logic [1:0]          act;
    logic [1:0]          rd_sel;
    logic [1:0]          wr_sel;
    logic [ADDR_LEN-1:0] req_addr  [2];
    logic [DATA_LEN-1:0] req_wdata [2];
    logic [1:0]          stall;
    logic [1:0]          done;

    logic grant_valid;
    logic grant;
    logic complete;

    assign rd_sel       = {p1_rd_req, p0_rd_req};
    assign wr_sel       = {p1_wr_req, p0_wr_req};
    assign act          = rd_sel | wr_sel;
    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_wdata[0] = p0_wr_data;
    assign req_wdata[1] = p1_wr_data;

    // Grant depends only on request lines and FSM state, never on c_miss,
    // so the cache's miss path cannot close a combinational loop through us.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (state_q == LOCK) begin
            grant_valid = 1'b1;
            grant       = lock_port_q;
        end else if (act == 2'b11) begin
            grant_valid = 1'b1;
            grant       = (FIXED_PRIO != 0) ? 1'b1 : rr_ptr_q;
        end else if (act[0]) begin
            grant_valid = 1'b1;
            grant       = 1'b0;
        end else if (act[1]) begin
            grant_valid = 1'b1;
            grant       = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign stall[gi] = act[gi] & ~(grant_valid & (grant == 1'(gi)) & ~c_miss);
            assign done[gi]  = act[gi] & grant_valid & (grant == 1'(gi)) & ~c_miss;
        end
    endgenerate

    assign complete = |done;

    // A simultaneous rd+wr on one port is forwarded as a write only.
    always_comb begin
        c_addr    = '0;
        c_wr_data = '0;
        c_rd_req  = 1'b0;
        c_wr_req  = 1'b0;
        if (grant_valid) begin
            c_addr    = req_addr[grant];
            c_wr_data = req_wdata[grant];
            if (!rst) begin
                c_wr_req = wr_sel[grant];
                c_rd_req = rd_sel[grant] & ~wr_sel[grant];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant_valid && c_miss) begin
                    state_d     = LOCK;
                    lock_port_d = grant;
                end
            end
            LOCK: begin
                if (!c_miss) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            rr_ptr_d = ~grant;
        end
    end

    always_comb begin
        rd_valid_d = '0;
        for (int i = 0; i < 2; i++) begin
            rd_data_d[i]  = rd_data_q[i];
            cnt_done_d[i] = cnt_done_q[i];
            cnt_wait_d[i] = cnt_wait_q[i];
            if (done[i] && !wr_sel[i]) begin
                rd_valid_d[i] = 1'b1;
                rd_data_d[i]  = c_rd_data;
            end
            if (done[i] && !(&cnt_done_q[i])) begin
                cnt_done_d[i] = cnt_done_q[i] + CNT_LEN'(1);
            end
            if (act[i] && stall[i] && !(&cnt_wait_q[i])) begin
                cnt_wait_d[i] = cnt_wait_q[i] + CNT_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_port_q <= 1'b0;
            rr_ptr_q    <= 1'b0;
            rd_valid_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                rd_data_q[i]  <= '0;
                cnt_done_q[i] <= '0;
                cnt_wait_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
            rd_valid_q  <= rd_valid_d;
            for (int i = 0; i < 2; i++) begin
                rd_data_q[i]  <= rd_data_d[i];
                cnt_done_q[i] <= cnt_done_d[i];
                cnt_wait_q[i] <= cnt_wait_d[i];
            end
        end
    end

    assign p0_stall    = stall[0];
    assign p1_stall    = stall[1];
    assign p0_rd_valid = rd_valid_q[0];
    assign p1_rd_valid = rd_valid_q[1];
    assign p0_rd_data  = rd_data_q[0];
    assign p1_rd_data  = rd_data_q[1];
    assign cnt_done0   = cnt_done_q[0];
    assign cnt_done1   = cnt_done_q[1];
    assign cnt_wait0   = cnt_wait_q[0];
    assign cnt_wait1   = cnt_wait_q[1];

endmodule
